// File: rtl/pack_stream_buffer_if.sv
// Bus bundle for pack_stream_buffer: push side, stream controls and packed output.
// The master modport belongs to the producer/consumer environment; the slave
// modport belongs to the buffer itself.
interface pack_stream_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384,
    parameter int PACK   = 2
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(PACK + 1);

    logic                   wr_en;
    logic [DATA_W-1:0]      wr_data;
    logic                   stream_en;
    logic                   drain;
    logic                   flush;
    logic                   out_ready;
    logic                   out_valid;
    logic [PACK*DATA_W-1:0] out_data;
    logic [NW-1:0]          out_words;
    logic [LW-1:0]          level;
    logic                   empty;
    logic                   full;
    logic                   overflow;

    modport master (
        output wr_en, wr_data, stream_en, drain, flush, out_ready,
        input  out_valid, out_data, out_words, level, empty, full, overflow
    );

    modport slave (
        input  wr_en, wr_data, stream_en, drain, flush, out_ready,
        output out_valid, out_data, out_words, level, empty, full, overflow
    );
endinterface

// File: rtl/pack_stream_buffer.sv
// Circular word buffer that emits beats of PACK concatenated words, oldest word
// in the MSBs. A short final beat (zero-padded in the LSBs) is allowed only while
// drain is high. Flush empties the buffer but keeps the sticky overflow flag.
//
// Output handshake: a beat transfers on any rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0 the beat (out_data, out_words)
// is held unchanged. A new beat may be loaded in the same edge the current one
// transfers, so back-to-back beats need no bubble.
module pack_stream_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384,
    parameter int PACK   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    pack_stream_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(PACK + 1);

    localparam logic [LW-1:0] PACK_L  = LW'(PACK);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [NW-1:0] PACK_N  = NW'(PACK);

    // Storage is deliberately left without a reset.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          level;
    logic                   out_valid;
    logic [PACK*DATA_W-1:0] out_data;
    logic [NW-1:0]          out_words;
    logic                   overflow;

    logic                   empty;
    logic                   full;
    logic                   slot_free;
    logic                   push;
    logic                   drop;
    logic                   full_pop;
    logic                   part_pop;
    logic [NW-1:0]          pop_n;
    logic [LW-1:0]          level_nxt;
    logic [PACK*DATA_W-1:0] beat;

    assign empty = (level == '0);
    assign full  = (level == DEPTH_L);

    // The slot can take a new beat if it is empty or its beat leaves this edge.
    assign slot_free = !out_valid || bus.out_ready;

    // A same-cycle pop never rescues a push against a full buffer.
    assign push = bus.wr_en && !full && !bus.flush && !reset;
    assign drop = bus.wr_en &&  full && !bus.flush;

    // Pop decisions look only at the registered level.
    assign full_pop = bus.stream_en && (level >= PACK_L) && slot_free;
    assign part_pop = bus.stream_en && bus.drain && (level != '0) &&
                      (level < PACK_L) && slot_free;

    // Number of words leaving the buffer this cycle (0 when no pop fires).
    always_comb begin
        pop_n = '0;
        if (!bus.flush) begin
            if (full_pop) begin
                pop_n = PACK_N;
            end else if (part_pop) begin
                pop_n = NW'(level);
            end
        end
    end

    assign level_nxt = level + LW'(push) - LW'(pop_n);

    // Gather the beat from rd_ptr onward, oldest word in the MSBs, unused LSBs zero.
    always_comb begin
        beat = '0;
        for (int i = 0; i < PACK; i++) begin
            if (NW'(i) < pop_n) begin
                beat[(PACK-1-i)*DATA_W +: DATA_W] = mem[rd_ptr + AW'(i)];
            end
        end
    end

    // Word storage write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers, level, output beat register and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_words <= '0;
            overflow  <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop_n != '0) begin
                out_data  <= beat;
                out_words <= pop_n;
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + AW'(pop_n);
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
            level <= level_nxt;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_words = out_words;
    assign bus.level     = level;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_pack_stream_buffer.sv
// Directed bench for pack_stream_buffer with DATA_W=32, DEPTH=8, PACK=2.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_pack_stream_buffer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int PACK   = 2;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    pack_stream_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PACK(PACK)) bus ();

    pack_stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PACK(PACK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.stream_en = 1'b0;
        bus.drain     = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data",  bus.out_data,       64'd0);
        chk("rst_words", 64'(bus.out_words), 64'd0);
        chk("rst_level", 64'(bus.level),     64'd0);
        chk("rst_empty", 64'(bus.empty),     64'd1);
        chk("rst_full",  64'(bus.full),      64'd0);
        chk("rst_ovf",   64'(bus.overflow),  64'd0);

        // Basic pack
        push_word(32'hA);
        chk("pk_level1", 64'(bus.level), 64'd1);
        push_word(32'hB);
        chk("pk_level2", 64'(bus.level), 64'd2);
        bus.stream_en = 1'b1;
        bus.out_ready = 1'b1;
        step();
        chk("pk_valid", 64'(bus.out_valid), 64'd1);
        chk("pk_data",  bus.out_data,       64'h0000000A_0000000B);
        chk("pk_words", 64'(bus.out_words), 64'd2);
        chk("pk_level0", 64'(bus.level),    64'd0);
        step();
        chk("pk_idle", 64'(bus.out_valid), 64'd0);
        chk("pk_empty", 64'(bus.empty),    64'd1);
        bus.stream_en = 1'b0;

        // Full and overflow: 9 pushes into 8 slots
        for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
        chk("ov_full8",  64'(bus.full),     64'd1);
        chk("ov_level8", 64'(bus.level),    64'd8);
        chk("ov_pre",    64'(bus.overflow), 64'd0);
        push_word(32'h108);
        chk("ov_level9", 64'(bus.level),    64'd8);
        chk("ov_flag",   64'(bus.overflow), 64'd1);
        bus.stream_en = 1'b1;
        step();
        chk("ov_beat0", bus.out_data, 64'h00000100_00000101);
        step();
        chk("ov_beat1", bus.out_data, 64'h00000102_00000103);
        step();
        chk("ov_beat2", bus.out_data, 64'h00000104_00000105);
        step();
        chk("ov_beat3", bus.out_data, 64'h00000106_00000107);
        chk("ov_lvl0",  64'(bus.level), 64'd0);
        step();
        chk("ov_nomore", 64'(bus.out_valid), 64'd0);
        bus.stream_en = 1'b0;

        // Flush keeps the sticky flag
        push_word(32'h1FF);
        do_flush();
        chk("fl_level", 64'(bus.level),    64'd0);
        chk("fl_empty", 64'(bus.empty),    64'd1);
        chk("fl_ovf",   64'(bus.overflow), 64'd1);

        // Backpressure
        for (int i = 0; i < 4; i++) push_word(32'h200 + 32'(i));
        bus.out_ready = 1'b0;
        bus.stream_en = 1'b1;
        step();
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_data",  bus.out_data,       64'h00000200_00000201);
        chk("bp_level", 64'(bus.level),     64'd2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_data",  bus.out_data,       64'h00000200_00000201);
            chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_level", 64'(bus.level),     64'd2);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_next",  bus.out_data,   64'h00000202_00000203);
        chk("bp_lvl0",  64'(bus.level), 64'd0);
        step();
        chk("bp_idle", 64'(bus.out_valid), 64'd0);
        bus.stream_en = 1'b0;

        // Wrap across index 7 -> 0
        do_flush();
        for (int i = 0; i < 6; i++) push_word(32'h300 + 32'(i));
        bus.stream_en = 1'b1;
        step();
        chk("wr_b0", bus.out_data, 64'h00000300_00000301);
        step();
        chk("wr_b1", bus.out_data, 64'h00000302_00000303);
        step();
        chk("wr_b2", bus.out_data, 64'h00000304_00000305);
        step();
        bus.stream_en = 1'b0;
        for (int i = 6; i < 10; i++) push_word(32'h300 + 32'(i));
        chk("wr_level4", 64'(bus.level), 64'd4);
        bus.stream_en = 1'b1;
        step();
        chk("wr_b3", bus.out_data, 64'h00000306_00000307);
        step();
        chk("wr_b4", bus.out_data, 64'h00000308_00000309);
        chk("wr_lvl0", 64'(bus.level), 64'd0);
        step();
        bus.stream_en = 1'b0;

        // A single word without drain must stay put
        do_flush();
        push_word(32'h4FF);
        bus.stream_en = 1'b1;
        step();
        chk("nd_valid", 64'(bus.out_valid), 64'd0);
        chk("nd_level", 64'(bus.level),     64'd1);
        bus.stream_en = 1'b0;

        // Drain with a partial final beat
        do_flush();
        for (int i = 0; i < 3; i++) push_word(32'h400 + 32'(i));
        bus.stream_en = 1'b1;
        bus.drain     = 1'b1;
        step();
        chk("dr_b0",    bus.out_data,       64'h00000400_00000401);
        chk("dr_w0",    64'(bus.out_words), 64'd2);
        chk("dr_lvl1",  64'(bus.level),     64'd1);
        step();
        chk("dr_b1",    bus.out_data,       64'h00000402_00000000);
        chk("dr_w1",    64'(bus.out_words), 64'd1);
        chk("dr_empty", 64'(bus.empty),     64'd1);
        step();
        chk("dr_idle",  64'(bus.out_valid), 64'd0);
        bus.stream_en = 1'b0;
        bus.drain     = 1'b0;

        // Reset mid-stream discards the in-flight beat and the sticky flag
        for (int i = 0; i < 4; i++) push_word(32'h500 + 32'(i));
        bus.out_ready = 1'b0;
        bus.stream_en = 1'b1;
        step();
        chk("rs_pre_valid", 64'(bus.out_valid), 64'd1);
        chk("rs_pre_ovf",   64'(bus.overflow),  64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.stream_en = 1'b0;
        chk("rs_valid", 64'(bus.out_valid), 64'd0);
        chk("rs_level", 64'(bus.level),     64'd0);
        chk("rs_ovf",   64'(bus.overflow),  64'd0);
        chk("rs_empty", 64'(bus.empty),     64'd1);
        chk("rs_data",  bus.out_data,       64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
